// File: rtl/muldiv_hilo_if.sv
// Request/response bundle for the HI/LO multiply-divide unit.
// The master drives operations and MTHI/MTLO writes; the slave returns status and HI/LO.
interface muldiv_hilo_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
// Define MULDIV_FAST_MULT_EN to replace the shift-add multiplier with a single-cycle product.
module muldiv_hilo (
  input logic          clk,
  input logic          reset,
  muldiv_hilo_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

`ifdef MULDIV_FAST_MULT_EN
  localparam state_e MulEntry = StFin;
`else
  localparam state_e MulEntry = StMul;
`endif

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  // acc_q: product high half / partial remainder; q_q: multiplier / dividend -> quotient
  logic [31:0] acc_q;
  logic [31:0] q_q;
  logic [31:0] b_mag_q;
  logic [4:0]  cnt_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        dbz_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_pulse_q;

  logic        signed_op;
  logic        is_div;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_mag;
  logic [63:0] prod_res;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    signed_op = ~bus.op[0];
    is_div    = bus.op[1];
    b_zero    = (bus.b == 32'd0);
    a_mag     = (signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    b_mag     = (signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_mag_q} : 33'd0);
    div_shift = {acc_q, q_q[31]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    // Partial remainder stays below the divisor, so bit 32 is a clean borrow flag.
    div_ge    = ~div_diff[32];
  end

  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_mag = {32'd0, q_q} * {32'd0, b_mag_q};
`else
    prod_mag = {acc_q, q_q};
`endif
    prod_res = neg_q_q ? (~prod_mag + 64'd1) : prod_mag;
    if (op_q[1]) begin
      res_lo = neg_q_q ? (~q_q + 32'd1) : q_q;
      res_hi = neg_r_q ? (~acc_q + 32'd1) : acc_q;
    end else begin
      res_hi = prod_res[63:32];
      res_lo = prod_res[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      acc_q       <= 32'd0;
      q_q         <= 32'd0;
      b_mag_q     <= 32'd0;
      cnt_q       <= 5'd0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            op_q    <= bus.op;
            q_q     <= a_mag;
            b_mag_q <= b_mag;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            neg_q_q <= signed_op & (bus.a[31] ^ bus.b[31]);
            neg_r_q <= signed_op & bus.a[31];
            busy_q  <= 1'b1;
            if (is_div && b_zero) begin
              dbz_q   <= 1'b1;
              state_q <= StFin;
            end else if (is_div) begin
              state_q <= StDiv;
            end else begin
              state_q <= MulEntry;
            end
          end
        end
        StMul: begin
          acc_q <= mul_sum[32:1];
          q_q   <= {mul_sum[0], q_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFin;
        end
        StDiv: begin
          acc_q <= div_ge ? div_diff[31:0] : div_shift[31:0];
          q_q   <= {q_q[30:0], div_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFin;
        end
        StFin: begin
          if (!dbz_q) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          done_q      <= 1'b1;
          dbz_pulse_q <= dbz_q;
          dbz_q       <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_pulse_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL provide: start  input  1  request to begin an operation; sampled only while busy=0.
REQ-004 SHALL provide: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL provide: a  input  32  multiplicand or dividend (rs).
REQ-006 SHALL provide: b  input  32  multiplier or divisor (rt).
REQ-007 SHALL provide: hi_we  input  1  MTHI write strobe.
REQ-008 SHALL provide: lo_we  input  1  MTLO write strobe.
REQ-009 SHALL provide: wdata  input  32  data for MTHI/MTLO.
REQ-010 SHALL provide: busy  output  1  high while an operation is in flight.
REQ-011 SHALL provide: done  output  1  one-cycle pulse marking HI/LO update.
REQ-012 SHALL provide: div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
REQ-013 SHALL provide: hi, lo  output  32 each  current HI/LO register contents (MFHI/MFLO source).

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIN: IDLE->MUL/DIV on accepted start, MUL/DIV->FIN after 32 iteration cycles, FIN->IDLE unconditionally.
REQ-015 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored without side effects.
REQ-016 SHALL latch a, b, op on the accepting edge; later input changes SHALL NOT affect the result.
REQ-017 SHALL assert busy from the cycle after the accepting edge until done; busy=0 during the done cycle.
REQ-018 SHALL use iterative shift-add multiply and restoring divide on 32-bit magnitudes, one bit per cycle; signed ops SHALL take magnitudes and sign-correct in FIN.
REQ-019 SHALL write HI/LO and pulse done on the edge 33 cycles after the accepting edge (done high cycle 34).
REQ-020 MULT/MULTU SHALL write HI = product[63:32], LO = product[31:0].
REQ-021 DIV/DIVU SHALL write LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-023 DIV/DIVU with b=0 SHALL skip iteration, go IDLE->FIN, leave HI/LO unchanged, pulse done and div_by_zero on the edge after acceptance.
REQ-024 hi_we/lo_we SHALL take effect only while busy=0 (IDLE), writing wdata on that edge; ignored while busy=1.
REQ-025 Same-edge start and hi_we/lo_we in IDLE SHALL apply the write and accept start; the operation result later overwrites both.
REQ-026 hi/lo outputs SHALL hold prior values throughout an operation until the done edge.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, clearing iteration counters/partials.
REQ-028 Reset mid-operation SHALL abort with no done pulse and no HI/LO write of the aborted result.

Configuration
REQ-029 With MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL use a single-cycle 32x32 product: IDLE->FIN, HI/LO written and done pulsed on the edge after acceptance; DIV unchanged.
REQ-030 Without MULDIV_FAST_MULT_EN, multiply SHALL be iterative per REQ-018/REQ-019 with no hardware multiplier inferred.

Verification
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 33 edges after start (1 edge with MULDIV_FAST_MULT_EN).
REQ-032 MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7 b=2 -> LO=3, HI=1.
REQ-033 MTHI 0x1234, MTLO 0x5678, then DIV b=0 -> done and div_by_zero high one edge later, HI=0x1234, LO=0x5678.
REQ-034 Start DIVU, reset=0 at iteration 10 -> busy=0, HI=LO=0 next cycle, no done pulse afterward.
REQ-035 During busy, pulse start (op=MULTU, a=b=2) and lo_we (wdata=0xAAAA) -> both ignored; only original result appears, exactly one done pulse.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero=0.
